// File: rtl/usb_pkg.sv
// Shared USB definitions: byte bus type, packet identifiers and the on-wire PID byte helper.
package usb_pkg;

    typedef logic [7:0] bus8_t;

    typedef enum logic [3:0] {
        PidOut   = 4'b0001,
        PidIn    = 4'b1001,
        PidSof   = 4'b0101,
        PidSetup = 4'b1101,
        PidData0 = 4'b0011,
        PidData1 = 4'b1011,
        PidAck   = 4'b0010,
        PidNak   = 4'b1010,
        PidStall = 4'b1110
    } usb_pid_t;

    // PID byte carries the PID in the low nibble and its complement in the high nibble.
    function automatic bus8_t pid_byte(usb_pid_t pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/usb_in_ctrl.sv
// IN-endpoint transaction controller: answers IN tokens with DATA0/DATA1, NAK or STALL,
// then waits for the host handshake and keeps per-endpoint data toggles.
module usb_in_ctrl
    import usb_pkg::*;
#(
    parameter int unsigned EP_N    = 4,
    parameter int unsigned MAX_PKT = 64,
    parameter int unsigned ACK_TMO = 80,
    localparam int unsigned LEN_W  = $clog2(MAX_PKT + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tok_valid,
    input  logic [3:0]              tok_pid,
    input  logic [3:0]              tok_ep,
    input  logic                    hs_valid,
    input  logic [3:0]              hs_pid,
    input  logic [EP_N-1:0]         ep_ready,
    input  logic [EP_N-1:0]         ep_stall,
    input  logic [EP_N*LEN_W-1:0]   ep_len,
    input  logic [EP_N-1:0]         ep_toggle_clr,
    output logic [3:0]              ep_sel,
    input  bus8_t                   ep_rdata,
    output logic                    ep_rd,
    output logic [EP_N-1:0]         ep_done,
    output logic [EP_N-1:0]         ep_retry,
    output logic                    tx_valid,
    output bus8_t                   tx_data,
    output logic                    tx_last,
    input  logic                    tx_ready,
    output logic                    busy
);

    localparam int unsigned EP_W  = (EP_N > 1) ? $clog2(EP_N) : 1;
    localparam int unsigned TMR_W = $clog2(ACK_TMO + 1);

    typedef enum logic [1:0] {
        StIdle,
        StSendPid,
        StSendData,
        StWaitAck
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       ep_q, ep_d;
    usb_pid_t         pid_q, pid_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [EP_N-1:0]  toggle_q, toggle_d;

    logic [LEN_W-1:0] len_arr [EP_N];
    logic [EP_W-1:0]  tok_idx;
    logic [EP_W-1:0]  ep_idx;
    logic             tok_hit;
    logic             pid_is_hs;
    logic             last_byte;
    logic [LEN_W-1:0] tok_len;

    always_comb begin
        for (int i = 0; i < int'(EP_N); i++) begin
            len_arr[i] = ep_len[i*LEN_W +: LEN_W];
        end
    end

    assign tok_idx   = tok_ep[EP_W-1:0];
    assign ep_idx    = ep_q[EP_W-1:0];
    assign tok_hit   = tok_valid && (tok_pid == PidIn) && (32'(tok_ep) < EP_N);
    assign pid_is_hs = (pid_q == PidNak) || (pid_q == PidStall);
    assign last_byte = (cnt_q == LEN_W'(len_q - 1'b1));
    assign tok_len   = (len_arr[tok_idx] > LEN_W'(MAX_PKT)) ? LEN_W'(MAX_PKT) : len_arr[tok_idx];

    assign ep_sel = ep_q;
    assign busy   = (state_q != StIdle);

    always_comb begin
        state_d  = state_q;
        ep_d     = ep_q;
        pid_d    = pid_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        toggle_d = toggle_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        ep_rd    = 1'b0;
        ep_done  = '0;
        ep_retry = '0;

        unique case (state_q)
            StIdle: begin
                if (tok_hit) begin
                    ep_d  = tok_ep;
                    len_d = tok_len;
                    if (ep_stall[tok_idx]) begin
                        pid_d = PidStall;
                    end else if (!ep_ready[tok_idx]) begin
                        pid_d = PidNak;
                    end else begin
                        pid_d = toggle_q[tok_idx] ? PidData1 : PidData0;
                    end
                    state_d = StSendPid;
                end
            end
            StSendPid: begin
                tx_valid = 1'b1;
                tx_data  = pid_byte(pid_q);
                tx_last  = pid_is_hs || (len_q == '0);
                if (tx_ready) begin
                    if (pid_is_hs) begin
                        state_d = StIdle;
                    end else if (len_q == '0) begin
                        state_d = StWaitAck;
                        timer_d = '0;
                    end else begin
                        state_d = StSendData;
                        cnt_d   = '0;
                    end
                end
            end
            StSendData: begin
                tx_valid = 1'b1;
                tx_data  = ep_rdata;
                tx_last  = last_byte;
                ep_rd    = tx_ready;
                if (tx_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_byte) begin
                        state_d = StWaitAck;
                        timer_d = '0;
                    end
                end
            end
            StWaitAck: begin
                timer_d = timer_q + 1'b1;
                if (hs_valid && (hs_pid == PidAck)) begin
                    toggle_d[ep_idx] = ~toggle_q[ep_idx];
                    ep_done[ep_idx]  = 1'b1;
                    state_d          = StIdle;
                end else if (hs_valid || (timer_q == TMR_W'(ACK_TMO - 1)) || tok_valid) begin
                    // An aborting token is dropped; the host will retry it.
                    ep_retry[ep_idx] = 1'b1;
                    state_d          = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Clear overrides a same-cycle ACK flip.
        toggle_d = toggle_d & ~ep_toggle_clr;

        if (rst) begin
            tx_valid = 1'b0;
            tx_data  = 8'h00;
            tx_last  = 1'b0;
            ep_rd    = 1'b0;
            ep_done  = '0;
            ep_retry = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ep_q     <= '0;
            pid_q    <= PidData0;
            len_q    <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            toggle_q <= '0;
        end else begin
            state_q  <= state_d;
            ep_q     <= ep_d;
            pid_q    <= pid_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            toggle_q <= toggle_d;
        end
    end

endmodule

// File: doc/usb_in_ctrl.md
Name: usb_in_ctrl

Overview:
- Transaction controller for IN endpoints of the USB 2.0 device.
- On a decoded IN token it drives the shared 8-bit transmit byte stream: a DATA0/DATA1 packet from the addressed endpoint buffer, or a NAK/STALL handshake.
- After sending data it waits for the host ACK and maintains per-endpoint data toggles.
- Sits between the token decoder/handshake receiver and the packet transmitter, which appends CRC16 to data packets.

Parameters:
- EP_N, 4, number of IN endpoints (0..EP_N-1), range 1..16.
- MAX_PKT, 64, maximum payload bytes; LEN_W = $clog2(MAX_PKT+1).
- ACK_TMO, 80, clk cycles to wait for a handshake after the last transmitted byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- tok_valid  in  1  one-cycle pulse: token decoded.
- tok_pid  in  4  token PID.
- tok_ep  in  4  token endpoint number.
- hs_valid  in  1  one-cycle pulse: handshake received from host.
- hs_pid  in  4  received handshake PID.
- ep_ready  in  EP_N  endpoint has a staged packet.
- ep_stall  in  EP_N  endpoint halted.
- ep_len  in  EP_N*LEN_W  staged packet length per endpoint, packed, ep0 at LSBs.
- ep_toggle_clr  in  EP_N  force the endpoint toggle to DATA0.
- ep_sel  out  4  endpoint currently being served; muxes ep_rdata externally.
- ep_rdata  in  8 (bus8_t)  first-word-fall-through byte from the selected buffer.
- ep_rd  out  1  pop one byte from the selected buffer.
- ep_done  out  EP_N  one-cycle pulse: packet ACKed, buffer may be released.
- ep_retry  out  EP_N  one-cycle pulse: packet not ACKed, buffer must rewind.
- tx_valid  out  1  transmit byte valid.
- tx_data  out  8 (bus8_t)  transmit byte.
- tx_last  out  1  final byte of packet.
- tx_ready  in  1  transmitter accepts byte.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state IDLE; all outputs 0; all toggles DATA0; timer and byte counter 0.
  - Applies mid-transaction: no done/retry pulse is issued.
- States: IDLE, SEND_PID, SEND_DATA, WAIT_ACK.
- IDLE:
  - Accepts tok_valid when tok_pid == IN (4'b1001) and tok_ep < EP_N: latches ep_sel=tok_ep, selects the PID, goes SEND_PID next cycle.
  - PID selection, in priority order: ep_stall -> STALL; else !ep_ready -> NAK; else DATA0/DATA1 per toggle.
  - Other PIDs, and tok_ep >= EP_N, are ignored (no response).
- SEND_PID:
  - tx_valid=1; tx_data={~pid,pid}; tx_last=1 for a handshake or for a zero-length data packet.
  - On tx_ready: handshake -> IDLE; len==0 -> WAIT_ACK; else -> SEND_DATA with cnt=0.
- SEND_DATA:
  - tx_valid=1; tx_data=ep_rdata; ep_rd = tx_ready (combinational with the transfer).
  - tx_last=(cnt==len-1); cnt increments on each transfer.
  - Transfer with tx_last -> WAIT_ACK; timer cleared.
- tx_valid/tx_data/tx_last hold stable while tx_ready=0; tx_valid never drops without a transfer.
- len is sampled from ep_len[ep_sel] on token accept and held; lengths > MAX_PKT are clamped to MAX_PKT.
- WAIT_ACK:
  - Timer increments each cycle.
  - hs_valid with ACK (4'b0010): toggle[ep] flips, ep_done[ep] pulses, -> IDLE.
  - hs_valid with any other PID, timer == ACK_TMO-1, or tok_valid: ep_retry[ep] pulses, no toggle change, -> IDLE.
  - A tok_valid that aborts WAIT_ACK is dropped, not serviced.
- tok_valid in SEND_PID/SEND_DATA is ignored.
- hs_valid outside WAIT_ACK is ignored.
- ep_toggle_clr acts in any state. If it coincides with an ACK flip on the same endpoint, the clear wins (DATA0).
- Latency: token accept -> tx_valid is 1 cycle. Last byte -> done/retry is ≥1 cycle.

Decomposition:
- Add to usb_pkg:
  - usb_pid_t: 4-bit enum — OUT 0001, IN 1001, SOF 0101, SETUP 1101, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110.
  - Function pid_byte(usb_pid_t) returning bus8_t {~pid,pid}.
- Timer, counter and toggle register stay inline; no sub-module is natural.

Test Plan:
- Reset, then IN ep1 with ep_ready[1]=1, len=3, bytes A1 A2 A3, tx_ready=1 → tx bytes C3,A1,A2,A3, tx_last on A3; three ep_rd pulses; ACK → ep_done=4'b0010; next packet starts 4B (DATA1).
- IN ep2 with ep_ready=0 → single byte 5A, tx_last=1, no ep_rd; with ep_stall[2]=1 → 1E.
- IN ep0, len=0 → single byte C3 with tx_last=1, then ACK → toggle flips; IN ep7 with EP_N=4 → no tx activity.
- No handshake after the last byte → ep_retry pulses exactly ACK_TMO cycles later; re-send uses the same toggle; NAK handshake gives the same result.
- tx_ready toggled 1/0 randomly over a 64-byte packet → every byte appears once in order, stable while stalled, exactly 64 ep_rd pulses.
- ep_toggle_clr[1] in the same cycle as ACK for ep1 → toggle 0; rst asserted mid SEND_DATA → next cycle tx_valid=0, busy=0, toggles 0, no done/retry pulse.
